// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the main-memory port arbiter: port count, port
//   indices and the read-tag carried alongside each outstanding read.
//   No ports (package).

package mem_port_arbiter_pkg;

    localparam int P_NUM_MEM_PORTS = 2;

    localparam logic MEM_PORT_CORE   = 1'b0;
    localparam logic MEM_PORT_PERIPH = 1'b1;

    // One outstanding-read marker: which requester gets the returning data.
    typedef struct packed {
        logic valid;
        logic port;
    } mem_tag_t;

    function automatic logic [P_NUM_MEM_PORTS-1:0] port_onehot(input logic port);
        return (port == MEM_PORT_PERIPH) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// mem_arb_tag_pipe
//   Shift register of read tags, P_DEPTH stages deep, so the tag emerges in
//   the same cycle the memory presents the read data.
//   Ports:
//     clk_i    clock
//     reset_i  synchronous active-high reset, clears every stage
//     tag_i    tag entering this cycle ({valid, port})
//     tag_o    tag leaving the last stage

module mem_arb_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int P_DEPTH = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] tag_i,
    output logic [1:0] tag_o
);

    mem_tag_t stage_q [P_DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= mem_tag_t'(tag_i);
            for (int i = 1; i < P_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[P_DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port main memory between the core (port 0) and a
//   peripheral master (port 1). At most one command is granted per cycle and
//   driven straight onto the memory port; reads are tagged and their data is
//   steered back to the issuing port after the memory latency.
//   Ports:
//     clk_i               clock
//     reset_i             synchronous active-high reset
//     req_i[1:0]          per-port request, command held until granted
//     we_i[1:0]           per-port write (1) / read (0)
//     addr0_i, addr1_i    per-port address
//     wdata0_i, wdata1_i  per-port write data
//     gnt_o[1:0]          one-hot grant, command accepted this cycle
//     rvalid_o[1:0]       one-hot, rdata_o valid for that port
//     rdata_o             read data shared by both ports
//     mem_address_o       memory address
//     mem_data_o          memory write data
//     mem_write_enable_o  memory write enable
//     mem_data_i          memory read data

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int P_ADDR_WIDTH     = 16,
    parameter int P_DATA_WIDTH     = 16,
    parameter int P_MEM_LATENCY    = 1,
    parameter int P_FIXED_PRIORITY = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [1:0]              req_i,
    input  logic [1:0]              we_i,
    input  logic [P_ADDR_WIDTH-1:0] addr0_i,
    input  logic [P_ADDR_WIDTH-1:0] addr1_i,
    input  logic [P_DATA_WIDTH-1:0] wdata0_i,
    input  logic [P_DATA_WIDTH-1:0] wdata1_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              rvalid_o,
    output logic [P_DATA_WIDTH-1:0] rdata_o,
    output logic [P_ADDR_WIDTH-1:0] mem_address_o,
    output logic [P_DATA_WIDTH-1:0] mem_data_o,
    output logic                    mem_write_enable_o,
    input  logic [P_DATA_WIDTH-1:0] mem_data_i
);

    // Port granted most recently; reset to the peripheral so the core wins
    // the first tie.
    logic     last_q;
    logic     last_d;
    logic     granted;
    logic     gnt_port;
    mem_tag_t tag_in;
    logic [1:0] tag_out_raw;
    mem_tag_t tag_out;

    always_comb begin
        gnt_o = 2'b00;
        if (!reset_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11: begin
                    if (P_FIXED_PRIORITY != 0) begin
                        gnt_o = 2'b01;
                    end else begin
                        gnt_o = (last_q == MEM_PORT_PERIPH) ? 2'b01 : 2'b10;
                    end
                end
                default: gnt_o = 2'b00;
            endcase
        end
    end

    assign granted  = |gnt_o;
    assign gnt_port = gnt_o[1] ? MEM_PORT_PERIPH : MEM_PORT_CORE;
    assign last_d   = granted ? gnt_port : last_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= MEM_PORT_PERIPH;
        end else begin
            last_q <= last_d;
        end
    end

    // Command mux: the granted port drives memory in the grant cycle itself.
    always_comb begin
        mem_address_o      = '0;
        mem_data_o         = '0;
        mem_write_enable_o = 1'b0;
        if (gnt_o[0]) begin
            mem_address_o      = addr0_i;
            mem_data_o         = wdata0_i;
            mem_write_enable_o = we_i[0];
        end else if (gnt_o[1]) begin
            mem_address_o      = addr1_i;
            mem_data_o         = wdata1_i;
            mem_write_enable_o = we_i[1];
        end
    end

    assign tag_in.valid = granted & ~mem_write_enable_o;
    assign tag_in.port  = gnt_port;

    mem_arb_tag_pipe #(
        .P_DEPTH (P_MEM_LATENCY)
    ) u_tag_pipe (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tag_i   (tag_in),
        .tag_o   (tag_out_raw)
    );

    assign tag_out = mem_tag_t'(tag_out_raw);

    // Gating by reset_i keeps a tag that is still sitting in the last stage
    // during the reset cycle from being returned.
    always_comb begin
        rvalid_o = 2'b00;
        rdata_o  = '0;
        if (!reset_i && tag_out.valid) begin
            rvalid_o = port_onehot(tag_out.port);
            rdata_o  = mem_data_i;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    typedef struct {
        int          due;
        logic [1:0]  rv;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic [1:0]  req   [2];
    logic [1:0]  we    [2];
    logic [15:0] a0    [2];
    logic [15:0] a1    [2];
    logic [15:0] d0    [2];
    logic [15:0] d1    [2];
    logic [1:0]  gnt   [2];
    logic [1:0]  rv    [2];
    logic [15:0] rdata [2];
    logic [15:0] maddr [2];
    logic [15:0] mdata [2];
    logic        mwe   [2];
    logic [15:0] mrd   [2];

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];
    logic [15:0] sh0  [0:65535];
    logic [15:0] rd0, rd1a, rd1b;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    // Instance 0: round-robin, latency 1.
    mem_port_arbiter #(
        .P_ADDR_WIDTH(16), .P_DATA_WIDTH(16), .P_MEM_LATENCY(1), .P_FIXED_PRIORITY(0)
    ) dut_rr (
        .clk_i(clk), .reset_i(rst[0]), .req_i(req[0]), .we_i(we[0]),
        .addr0_i(a0[0]), .addr1_i(a1[0]), .wdata0_i(d0[0]), .wdata1_i(d1[0]),
        .gnt_o(gnt[0]), .rvalid_o(rv[0]), .rdata_o(rdata[0]),
        .mem_address_o(maddr[0]), .mem_data_o(mdata[0]),
        .mem_write_enable_o(mwe[0]), .mem_data_i(mrd[0])
    );

    // Instance 1: fixed priority, latency 2.
    mem_port_arbiter #(
        .P_ADDR_WIDTH(16), .P_DATA_WIDTH(16), .P_MEM_LATENCY(2), .P_FIXED_PRIORITY(1)
    ) dut_fp (
        .clk_i(clk), .reset_i(rst[1]), .req_i(req[1]), .we_i(we[1]),
        .addr0_i(a0[1]), .addr1_i(a1[1]), .wdata0_i(d0[1]), .wdata1_i(d1[1]),
        .gnt_o(gnt[1]), .rvalid_o(rv[1]), .rdata_o(rdata[1]),
        .mem_address_o(maddr[1]), .mem_data_o(mdata[1]),
        .mem_write_enable_o(mwe[1]), .mem_data_i(mrd[1])
    );

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (mwe[0]) mem0[maddr[0]] <= mdata[0];
        rd0 <= mem0[maddr[0]];
    end

    always @(posedge clk) begin
        if (mwe[1]) mem1[maddr[1]] <= mdata[1];
        rd1a <= mem1[maddr[1]];
        rd1b <= rd1a;
    end

    assign mrd[0] = rd0;
    assign mrd[1] = rd1b;

    task automatic drive(input int inst, input logic r, input logic [1:0] rq, input logic [1:0] w,
                         input logic [15:0] x0, input logic [15:0] x1,
                         input logic [15:0] y0, input logic [15:0] y1);
        rst[inst] = r;
        req[inst] = rq;
        we[inst]  = w;
        a0[inst]  = x0;
        a1[inst]  = x1;
        d0[inst]  = y0;
        d1[inst]  = y1;
    endtask

    // One bus cycle: sample at the falling edge, compare, update the
    // scoreboard, then advance past the next rising edge.
    task automatic tick(input int inst, input logic [1:0] exp_gnt, input string tag);
        exp_t        e;
        logic [1:0]  erv;
        logic [15:0] erd, eaddr, edata;
        logic        ewe;
        int          lat;
        lat = (inst == 0) ? 1 : 2;
        @(negedge clk);
        if (rst[inst]) sb.delete();
        erv = 2'b00;
        erd = 16'h0000;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e   = sb.pop_front();
            erv = e.rv;
            erd = e.data;
        end
        checks++;
        assert (rv[inst] === erv) else begin
            errors++; $error("FAIL %s rvalid: observed %b expected %b", tag, rv[inst], erv);
        end
        checks++;
        assert (rdata[inst] === erd) else begin
            errors++; $error("FAIL %s rdata: observed %h expected %h", tag, rdata[inst], erd);
        end
        checks++;
        assert (gnt[inst] === exp_gnt) else begin
            errors++; $error("FAIL %s gnt: observed %b expected %b", tag, gnt[inst], exp_gnt);
        end
        eaddr = 16'h0000; edata = 16'h0000; ewe = 1'b0;
        if (exp_gnt == 2'b01) begin
            eaddr = a0[inst]; edata = d0[inst]; ewe = we[inst][0];
        end else if (exp_gnt == 2'b10) begin
            eaddr = a1[inst]; edata = d1[inst]; ewe = we[inst][1];
        end
        checks++;
        assert (maddr[inst] === eaddr) else begin
            errors++; $error("FAIL %s mem_addr: observed %h expected %h", tag, maddr[inst], eaddr);
        end
        checks++;
        assert (mdata[inst] === edata) else begin
            errors++; $error("FAIL %s mem_data: observed %h expected %h", tag, mdata[inst], edata);
        end
        checks++;
        assert (mwe[inst] === ewe) else begin
            errors++; $error("FAIL %s mem_we: observed %b expected %b", tag, mwe[inst], ewe);
        end
        if (exp_gnt != 2'b00) begin
            if (!ewe) sb.push_back('{cyc + lat, exp_gnt, (inst == 0) ? sh0[eaddr] : pat(eaddr)});
            else if (inst == 0) sh0[eaddr] = edata;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = pat(16'(i));
            mem1[i] = pat(16'(i));
            sh0[i]  = pat(16'(i));
        end
        mem0[16'h0010] = 16'hBEEF;
        sh0[16'h0010]  = 16'hBEEF;

        drive(0, 1'b1, 2'b11, 2'b11, 16'h1111, 16'h2222, 16'hAAAA, 16'h5555);
        drive(1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk); #1;

        // Round-robin, latency 1
        tick(0, 2'b00, "reset0");
        tick(0, 2'b00, "reset1");
        tick(0, 2'b00, "reset2");
        drive(0, 1'b0, 2'b11, 2'b00, 16'h0020, 16'h0030, 16'h0000, 16'h0000);
        tick(0, 2'b01, "rr0");
        drive(0, 1'b0, 2'b11, 2'b00, 16'h0021, 16'h0031, 16'h0000, 16'h0000);
        tick(0, 2'b10, "rr1");
        drive(0, 1'b0, 2'b11, 2'b00, 16'h0022, 16'h0032, 16'h0000, 16'h0000);
        tick(0, 2'b01, "rr2");
        drive(0, 1'b0, 2'b11, 2'b00, 16'h0023, 16'h0033, 16'h0000, 16'h0000);
        tick(0, 2'b10, "rr3");
        drive(0, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick(0, 2'b00, "rr_drain0");
        tick(0, 2'b00, "rr_drain1");
        drive(0, 1'b0, 2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        tick(0, 2'b01, "rd_beef");
        drive(0, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick(0, 2'b00, "rd_beef_ret");
        drive(0, 1'b0, 2'b10, 2'b10, 16'h0000, 16'h0200, 16'h0000, 16'h1234);
        tick(0, 2'b10, "wr_p1");
        drive(0, 1'b0, 2'b10, 2'b00, 16'h0000, 16'h0200, 16'h0000, 16'h0000);
        tick(0, 2'b10, "rd_back");
        drive(0, 1'b0, 2'b11, 2'b01, 16'h0040, 16'h0041, 16'hCAFE, 16'h0000);
        tick(0, 2'b01, "mix_wr0");
        drive(0, 1'b0, 2'b11, 2'b00, 16'h0040, 16'h0041, 16'h0000, 16'h0000);
        tick(0, 2'b10, "mix_rd1");
        tick(0, 2'b01, "mix_rd0");
        tick(0, 2'b10, "wd_tie");
        drive(0, 1'b0, 2'b00, 2'b00, 16'h0040, 16'h0041, 16'h0000, 16'h0000);
        tick(0, 2'b00, "wd_none");
        drive(0, 1'b0, 2'b01, 2'b00, 16'h0010, 16'h0041, 16'h0000, 16'h0000);
        tick(0, 2'b01, "pre_rst");
        drive(0, 1'b1, 2'b11, 2'b00, 16'h0010, 16'h0041, 16'h0000, 16'h0000);
        tick(0, 2'b00, "mid_rst");
        drive(0, 1'b0, 2'b11, 2'b00, 16'h0050, 16'h0051, 16'h0000, 16'h0000);
        tick(0, 2'b01, "post_rst0");
        tick(0, 2'b10, "post_rst1");
        drive(0, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick(0, 2'b00, "end_drain0");
        tick(0, 2'b00, "end_drain1");
        checks++;
        assert (sb.size() == 0) else begin
            errors++; $error("FAIL rr_leftover: observed %0d pending expected 0", sb.size());
        end
        sb.delete();

        // Fixed priority, latency 2
        drive(0, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        drive(1, 1'b1, 2'b11, 2'b00, 16'h0060, 16'h0070, 16'h0000, 16'h0000);
        tick(1, 2'b00, "fp_reset0");
        tick(1, 2'b00, "fp_reset1");
        drive(1, 1'b0, 2'b11, 2'b00, 16'h0060, 16'h0070, 16'h0000, 16'h0000);
        tick(1, 2'b01, "fp_tie0");
        drive(1, 1'b0, 2'b11, 2'b00, 16'h0061, 16'h0070, 16'h0000, 16'h0000);
        tick(1, 2'b01, "fp_tie1");
        drive(1, 1'b0, 2'b11, 2'b00, 16'h0062, 16'h0070, 16'h0000, 16'h0000);
        tick(1, 2'b01, "fp_tie2");
        drive(1, 1'b0, 2'b10, 2'b00, 16'h0062, 16'h0070, 16'h0000, 16'h0000);
        tick(1, 2'b10, "fp_p1");
        drive(1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick(1, 2'b00, "fp_drain0");
        tick(1, 2'b00, "fp_drain1");
        tick(1, 2'b00, "fp_drain2");
        drive(1, 1'b0, 2'b10, 2'b00, 16'h0000, 16'h0071, 16'h0000, 16'h0000);
        tick(1, 2'b10, "fp_pre_rst");
        drive(1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0071, 16'h0000, 16'h0000);
        tick(1, 2'b00, "fp_mid_rst");
        drive(1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick(1, 2'b00, "fp_post_rst0");
        tick(1, 2'b00, "fp_post_rst1");
        checks++;
        assert (sb.size() == 0) else begin
            errors++; $error("FAIL fp_leftover: observed %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
